// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe board controller.
// Contents:
//   cell_t    - per-cell mark encoding (EMPTY/X/O)
//   state_t   - board controller FSM states
//   NUM_CELLS - number of board cells
//   WIN_LINES - the eight winning-line masks, bit i set for cell i
package tictactoe_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned NUM_LINES = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    WIN   = 2'd2,
    DRAW  = 2'd3
  } state_t;

  // Index 0 sits in the low nine bits; listing order below is line 7 down to line 0.
  localparam logic [NUM_LINES-1:0][NUM_CELLS-1:0] WIN_LINES = {
    9'b001_010_100,  // 7: diagonal 2-4-6
    9'b100_010_001,  // 6: diagonal 0-4-8
    9'b100_100_100,  // 5: column 2-5-8
    9'b010_010_010,  // 4: column 1-4-7
    9'b001_001_001,  // 3: column 0-3-6
    9'b111_000_000,  // 2: row 6-7-8
    9'b000_111_000,  // 1: row 3-4-5
    9'b000_000_111   // 0: row 0-1-2
  };

endpackage

// File: rtl/tictactoe_win_detect.sv
// Combinational winning-line detector.
// Ports:
//   board    - packed board, cell i at bits [2i+1:2i]
//   winner   - mark owning the reported line, 00 when none
//   win_line - cell mask of the reported line, 0 when none
// When several lines are complete the lowest-indexed one is reported.
module tictactoe_win_detect
  import tictactoe_pkg::*;
(
  input  logic [2*NUM_CELLS-1:0] board,
  output logic [1:0]             winner,
  output logic [NUM_CELLS-1:0]   win_line
);

  logic [NUM_CELLS-1:0] x_cells;
  logic [NUM_CELLS-1:0] o_cells;

  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++) begin
      x_cells[i] = (board[2*i +: 2] == X);
      o_cells[i] = (board[2*i +: 2] == O);
    end
  end

  // Scan from the highest line down so the lowest-indexed match is assigned last.
  always_comb begin
    winner   = EMPTY;
    win_line = '0;
    for (int l = NUM_LINES - 1; l >= 0; l--) begin
      if ((x_cells & WIN_LINES[l]) == WIN_LINES[l]) begin
        winner   = X;
        win_line = WIN_LINES[l];
      end else if ((o_cells & WIN_LINES[l]) == WIN_LINES[l]) begin
        winner   = O;
        win_line = WIN_LINES[l];
      end
    end
  end

endmodule

// File: rtl/tictactoe_board_ctrl.sv
// Tic-tac-toe board controller.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   dato          - selected cell index (0-8 valid, 9-15 invalid)
//   place_pulse   - single-cycle confirm strobe
//   new_game      - single-cycle strobe clearing the board
//   board         - packed board, cell i at bits [2i+1:2i]
//   turn          - mark that moves next
//   winner        - winning mark, 00 when none
//   win_line      - cell mask of the winning line
//   game_over     - high in WIN or DRAW
//   draw          - high in DRAW
//   invalid_move  - one-cycle pulse on a rejected placement
// A placement is written in PLAY; the following cycle (CHECK) evaluates the
// registered board and either ends the game or hands the turn over.
module tictactoe_board_ctrl
  import tictactoe_pkg::*;
#(
  parameter int unsigned NUM_CELLS    = 9,
  parameter logic [1:0]  FIRST_PLAYER = 2'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             dato,
  input  logic                   place_pulse,
  input  logic                   new_game,
  output logic [2*NUM_CELLS-1:0] board,
  output logic [1:0]             turn,
  output logic [1:0]             winner,
  output logic [NUM_CELLS-1:0]   win_line,
  output logic                   game_over,
  output logic                   draw,
  output logic                   invalid_move
);

  state_t                 state_q, state_d;
  logic [2*NUM_CELLS-1:0] board_q, board_d;
  logic [1:0]             turn_q, turn_d;
  logic [1:0]             winner_q, winner_d;
  logic [NUM_CELLS-1:0]   win_line_q, win_line_d;
  logic [3:0]             move_cnt_q, move_cnt_d;
  logic                   invalid_q, invalid_d;

  logic [1:0]             det_winner;
  logic [NUM_CELLS-1:0]   det_line;
  logic                   dato_ok;
  logic [1:0]             sel_cell;

  tictactoe_win_detect u_win_detect (
    .board    (board_q),
    .winner   (det_winner),
    .win_line (det_line)
  );

  assign dato_ok = (dato < 4'(NUM_CELLS));

  // Loop-based mux keeps the out-of-range indices 9-15 from ever selecting board bits.
  always_comb begin
    sel_cell = 2'b11;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (dato == 4'(i)) begin
        sel_cell = board_q[2*i +: 2];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    win_line_d = win_line_q;
    move_cnt_d = move_cnt_q;
    invalid_d  = 1'b0;

    if (new_game) begin
      state_d    = PLAY;
      board_d    = '0;
      turn_d     = FIRST_PLAYER;
      winner_d   = EMPTY;
      win_line_d = '0;
      move_cnt_d = '0;
    end else begin
      unique case (state_q)
        PLAY: begin
          if (place_pulse) begin
            if (dato_ok && (sel_cell == EMPTY)) begin
              for (int i = 0; i < NUM_CELLS; i++) begin
                if (dato == 4'(i)) begin
                  board_d[2*i +: 2] = turn_q;
                end
              end
              if (move_cnt_q != 4'(NUM_CELLS)) begin
                move_cnt_d = move_cnt_q + 4'd1;
              end
              state_d = CHECK;
            end else begin
              invalid_d = 1'b1;
            end
          end
        end
        CHECK: begin
          // Win takes priority so a line completed on the last move is not a draw.
          if (det_winner != EMPTY) begin
            winner_d   = det_winner;
            win_line_d = det_line;
            state_d    = WIN;
          end else if (move_cnt_q == 4'(NUM_CELLS)) begin
            state_d = DRAW;
          end else begin
            turn_d  = (turn_q == X) ? O : X;
            state_d = PLAY;
          end
        end
        WIN, DRAW: begin
          state_d = state_q;
        end
        default: begin
          state_d = PLAY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= PLAY;
      board_q    <= '0;
      turn_q     <= FIRST_PLAYER;
      winner_q   <= EMPTY;
      win_line_q <= '0;
      move_cnt_q <= '0;
      invalid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      win_line_q <= win_line_d;
      move_cnt_q <= move_cnt_d;
      invalid_q  <= invalid_d;
    end
  end

  assign board        = board_q;
  assign turn         = turn_q;
  assign winner       = winner_q;
  assign win_line     = win_line_q;
  assign game_over    = (state_q == WIN) || (state_q == DRAW);
  assign draw         = (state_q == DRAW);
  assign invalid_move = invalid_q;

endmodule

// File: tb/tb_tictactoe_board_ctrl.sv
module tb_tictactoe_board_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  dato = 4'd0;
  logic        place_pulse = 1'b0;
  logic        new_game = 1'b0;
  logic [17:0] board;
  logic [1:0]  turn;
  logic [1:0]  winner;
  logic [8:0]  win_line;
  logic        game_over;
  logic        draw;
  logic        invalid_move;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tictactoe_board_ctrl #(
    .NUM_CELLS    (9),
    .FIRST_PLAYER (2'd1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dato         (dato),
    .place_pulse  (place_pulse),
    .new_game     (new_game),
    .board        (board),
    .turn         (turn),
    .winner       (winner),
    .win_line     (win_line),
    .game_over    (game_over),
    .draw         (draw),
    .invalid_move (invalid_move)
  );

  // Game model: status 0 = awaiting move, 1 = move just written, 2 = won, 3 = drawn.
  int         m_board [9];
  int         m_turn;
  int         m_winner;
  logic [8:0] m_line;
  int         m_status;
  bit         m_inv;
  int         lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                               '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

  task automatic m_reset();
    foreach (m_board[i]) m_board[i] = 0;
    m_turn   = 1;
    m_winner = 0;
    m_line   = '0;
    m_status = 0;
    m_inv    = 1'b0;
  endtask

  task automatic model_step(input bit pl, input bit ng, input int d);
    bit found;
    bit full;
    int a, b, c;
    m_inv = 1'b0;
    if (ng) begin
      m_reset();
    end else if (m_status == 0) begin
      if (pl) begin
        if (d <= 8 && m_board[d] == 0) begin
          m_board[d] = m_turn;
          m_status   = 1;
        end else begin
          m_inv = 1'b1;
        end
      end
    end else if (m_status == 1) begin
      found = 1'b0;
      for (int l = 0; l < 8; l++) begin
        a = lines[l][0]; b = lines[l][1]; c = lines[l][2];
        if (!found && m_board[a] != 0 && m_board[a] == m_board[b] && m_board[b] == m_board[c]) begin
          found    = 1'b1;
          m_winner = m_board[a];
          m_line   = 9'(1 << a) | 9'(1 << b) | 9'(1 << c);
        end
      end
      full = 1'b1;
      foreach (m_board[i]) if (m_board[i] == 0) full = 1'b0;
      if (found) m_status = 2;
      else if (full) m_status = 3;
      else begin
        m_turn   = (m_turn == 1) ? 2 : 1;
        m_status = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [17:0] exp_board;
    for (int i = 0; i < 9; i++) exp_board[2*i +: 2] = 2'(m_board[i]);
    chk("board", 32'(board), 32'(exp_board));
    chk("turn", 32'(turn), 32'(m_turn));
    chk("winner", 32'(winner), 32'(m_winner));
    chk("win_line", 32'(win_line), 32'(m_line));
    chk("game_over", 32'(game_over), 32'(m_status >= 2));
    chk("draw", 32'(draw), 32'(m_status == 3));
    chk("invalid_move", 32'(invalid_move), 32'(m_inv));
  endtask

  task automatic cycle(input bit pl, input bit ng, input logic [3:0] d);
    place_pulse = pl;
    new_game    = ng;
    dato        = d;
    @(posedge clk);
    model_step(pl, ng, int'(d));
    #1;
    place_pulse = 1'b0;
    new_game    = 1'b0;
    compare_all();
  endtask

  task automatic place(input logic [3:0] d);
    cycle(1'b1, 1'b0, d);
    cycle(1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    logic [17:0] saved;
    int seq_draw [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int seq_win9 [9] = '{0, 1, 2, 5, 3, 6, 4, 7, 8};
    int seq_xwin [5] = '{0, 3, 1, 4, 2};
    bit pl, ng;
    logic [3:0] d;

    m_reset();
    #22;
    chk("reset_board", 32'(board), 32'h0);
    chk("reset_turn", 32'(turn), 32'h1);
    chk("reset_game_over", 32'(game_over), 32'h0);
    compare_all();
    rst = 1'b0;

    // X wins along the top row
    foreach (seq_xwin[i]) place(4'(seq_xwin[i]));
    chk("xwin_winner", 32'(winner), 32'h1);
    chk("xwin_line", 32'(win_line), 32'h007);
    chk("xwin_game_over", 32'(game_over), 32'h1);

    // Terminal lock
    saved = board;
    cycle(1'b1, 1'b0, 4'd5);
    chk("lock_board", 32'(board), 32'(saved));
    chk("lock_no_invalid", 32'(invalid_move), 32'h0);
    cycle(1'b0, 1'b1, 4'd0);
    chk("newgame_board", 32'(board), 32'h0);
    chk("newgame_turn", 32'(turn), 32'h1);
    chk("newgame_game_over", 32'(game_over), 32'h0);

    // Invalid moves
    place(4'd4);
    cycle(1'b1, 1'b0, 4'd4);
    chk("inv_occupied_pulse", 32'(invalid_move), 32'h1);
    cycle(1'b0, 1'b0, 4'd0);
    chk("inv_pulse_width", 32'(invalid_move), 32'h0);
    cycle(1'b1, 1'b0, 4'd12);
    chk("inv_range_pulse", 32'(invalid_move), 32'h1);
    cycle(1'b0, 1'b0, 4'd0);
    chk("inv_board", 32'(board), 32'h100);
    chk("inv_turn", 32'(turn), 32'h2);

    // Draw
    cycle(1'b0, 1'b1, 4'd0);
    foreach (seq_draw[i]) place(4'(seq_draw[i]));
    chk("draw_flag", 32'(draw), 32'h1);
    chk("draw_winner", 32'(winner), 32'h0);
    chk("draw_game_over", 32'(game_over), 32'h1);

    // Win on the ninth move via 0-4-8
    cycle(1'b0, 1'b1, 4'd0);
    foreach (seq_win9[i]) place(4'(seq_win9[i]));
    chk("win9_winner", 32'(winner), 32'h1);
    chk("win9_line", 32'(win_line), 32'h111);
    chk("win9_draw", 32'(draw), 32'h0);

    // new_game collides with place_pulse
    cycle(1'b0, 1'b1, 4'd0);
    place(4'd0);
    cycle(1'b1, 1'b1, 4'd4);
    chk("collide_board", 32'(board), 32'h0);
    cycle(1'b0, 1'b0, 4'd0);

    // Back-to-back pulses: second lands in CHECK
    cycle(1'b1, 1'b0, 4'd1);
    cycle(1'b1, 1'b0, 4'd2);
    chk("b2b_board", 32'(board), 32'h4);
    chk("b2b_no_invalid", 32'(invalid_move), 32'h0);
    cycle(1'b0, 1'b0, 4'd0);

    // Async reset while in CHECK
    cycle(1'b1, 1'b0, 4'd5);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_board", 32'(board), 32'h0);
    chk("arst_turn", 32'(turn), 32'h1);
    chk("arst_winner", 32'(winner), 32'h0);
    m_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // Randomized play
    for (int n = 0; n < 4000; n++) begin
      pl = ($urandom_range(0, 2) == 0);
      ng = (m_status >= 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 60) == 0);
      d  = $urandom_range(0, 1) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
      cycle(pl, ng, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tictactoe_board_ctrl.md
# tictactoe_board_ctrl

Game-board controller that sits directly downstream of the KEY0 cell-selection counter. It consumes the 4-bit cell index (0–8), and on a debounced confirm pulse it writes the current player's mark into the selected cell. It then checks the eight winning lines, alternates turns, and exposes board, turn and result state to the VGA renderer.

## Interface
Parameters:
- `NUM_CELLS`, default 9: board cells, indexed 0–8 row-major (0 = top-left, 8 = bottom-right).
- `FIRST_PLAYER`, default 1: mark that moves first after reset or new game (1 = X, 2 = O).

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `dato`, input, 4: selected cell index from the cell-selection counter; values 9–15 are invalid.
- `place_pulse`, input, 1: single-cycle confirm strobe, synchronous to `clk`, already debounced upstream.
- `new_game`, input, 1: single-cycle strobe that clears the board and restarts.
- `board`, output, 18: cell *i* occupies bits [2i+1:2i]; 00 = empty, 01 = X, 10 = O, 11 = never driven.
- `turn`, output, 2: mark that moves next (01 or 10).
- `winner`, output, 2: 00 = none, 01 = X, 10 = O.
- `win_line`, output, 9: one-hot-per-cell mask of the winning line; 0 if there is no winner.
- `game_over`, output, 1: high in WIN or DRAW.
- `draw`, output, 1: high in DRAW only.
- `invalid_move`, output, 1: one-cycle pulse when a placement is rejected.

## Operation
FSM states: PLAY, CHECK, WIN, DRAW.

- **PLAY**, on `place_pulse`:
  - If `dato` ≤ 8 and that cell is empty: write `turn` into the cell, go to CHECK.
  - If `dato` > 8 or the cell is occupied: pulse `invalid_move`; board and turn are unchanged; stay in PLAY.
- **CHECK**, evaluating the registered board:
  - Any of the 8 lines full with one mark: set `winner` and `win_line`, go to WIN. Rows are 012/345/678, columns 036/147/258, diagonals 048/246.
  - Otherwise all 9 cells occupied: go to DRAW.
  - Otherwise: toggle `turn`, go to PLAY.
  - A win on the ninth move is a WIN, not a DRAW.
- **WIN / DRAW**: terminal states.
  - `place_pulse` is ignored with no `invalid_move` pulse.
  - Only `new_game` or `rst` leaves them.
- **`new_game`** in any state: clear the board, set `turn` = `FIRST_PLAYER`, `winner` = 0, `win_line` = 0, go to PLAY.
- **Simultaneous events**:
  - `new_game` and `place_pulse` in the same cycle: `new_game` wins and the placement is dropped.
  - `place_pulse` arriving in CHECK is ignored with no `invalid_move` pulse.
- **Move count**: a 4-bit internal counter, 0–9, increments on each accepted write. `move_cnt` == 9 is the draw condition; it never wraps.

## Timing
- **Reset values** (async assert on `rst`): `board` = 0, `turn` = `FIRST_PLAYER`, `winner` = 0, `win_line` = 0, `game_over` = 0, `draw` = 0, `invalid_move` = 0, state = PLAY, move count = 0.
- **Reset mid-operation** (including mid-CHECK) returns everything to those values with no partial write.
- **Accepted `place_pulse` at edge N**: `board` is updated after edge N. The CHECK result is visible after edge N+1: toggled `turn`, or `winner`/`win_line`/`game_over`.
- **Rejected `place_pulse` at edge N**: `invalid_move` is high for exactly the cycle after edge N.
- **`new_game` at edge N**: all outputs are at their cleared values after edge N.
- **Registered outputs**: all outputs are registered; no combinational path from inputs to outputs.
- **Consecutive pulses**: back-to-back `place_pulse` on N and N+1 leaves the second one ignored (it lands in CHECK). The upstream stage guarantees ≥ 2-cycle spacing in practice.

## Structure
- **Shared package `tictactoe_pkg`** contains:
  - `cell_t` enum (EMPTY = 2'b00, X = 2'b01, O = 2'b10).
  - `state_t` enum (PLAY, CHECK, WIN, DRAW).
  - `NUM_CELLS`.
  - `WIN_LINES`: a constant array of 8 nine-bit masks.
- **Sub-module `tictactoe_win_detect`**: purely combinational; takes `board` and returns `winner` and `win_line`. It is instantiated once and sampled in CHECK. The lowest-indexed matching line is reported.

## Test plan
- **Alternating play, X wins**: from reset, place cells 0, 3, 1, 4, 2 → after the fifth CHECK, `winner` = 01, `win_line` = 9'b000000111, `game_over` = 1.
- **Invalid moves**: place cell 4, then cell 4 again, then `dato` = 12 → two `invalid_move` single-cycle pulses; `board` holds only X at cell 4; `turn` = 10.
- **Draw**: fill 0, 1, 2, 4, 3, 5, 7, 6, 8 (X O X O X O X O X... per turn order) with no line → `draw` = 1, `winner` = 0. A ninth-move completion of 0-4-8 instead yields WIN.
- **Terminal lock**: after a WIN, `place_pulse` on an empty cell → `board` unchanged and no `invalid_move` pulse. Then `new_game` → `board` = 0, `turn` = 01, state PLAY.
- **Collisions and reset**:
  - `new_game` and `place_pulse` in the same cycle → board cleared, no write.
  - `rst` asserted during CHECK → all outputs return to reset values immediately, asynchronously.
